weights_bram_reader: RTL and testbench

WEIGHTS_BRAM_READER -- requirements
Module: weights_bram_reader

---
 rtl/weights_bram_reader.sv | 146 ++++++++++++++
 tb/tb_weights_bram_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/weights_bram_reader.sv
// rtl/weights_bram_reader.sv - streams a block of weight words from a BRAM read port (macro WEIGHTS_RD_REPEAT_EN adds reps)
module weights_bram_reader #(
    parameter int R_DEPTH      = 8,
    parameter int R_DATA_WIDTH = 8,
    localparam int ADDR_W      = $clog2(R_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base,
    input  logic [ADDR_W:0]         len,
`ifdef WEIGHTS_RD_REPEAT_EN
    input  logic [7:0]              reps,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    enb,
    output logic [ADDR_W-1:0]       addrb,
    input  logic [R_DATA_WIDTH-1:0] doutb,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [R_DATA_WIDTH-1:0] m_data,
    output logic                    m_last
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(R_DEPTH - 1);
    localparam logic [ADDR_W:0]   ONE_WORD  = (ADDR_W+1)'(1);

    state_t                  state;
    logic [ADDR_W-1:0]       base_q;
    logic [ADDR_W:0]         len_q;
    logic [ADDR_W:0]         rd_left;
    logic [7:0]              rep_left;
    logic [7:0]              rep_val;
    logic                    inflight;
    logic                    inflight_last;
    logic [R_DATA_WIDTH-1:0] fifo_data [3];
    logic                    fifo_last [3];
    logic [1:0]              wr_ptr;
    logic [1:0]              rd_ptr;
    logic [1:0]              count;
    logic                    issue;
    logic                    final_issue;
    logic                    pop;

`ifdef WEIGHTS_RD_REPEAT_EN
    assign rep_val = (reps == 8'd0) ? 8'd1 : reps;
`else
    assign rep_val = 8'd1;
`endif

    // Reads still in the BRAM pipeline count against FIFO space so nothing overflows.
    assign issue       = (state == READ) && (({1'b0, count} + {2'b00, inflight}) < 3'd3);
    assign final_issue = issue && (rd_left == ONE_WORD) && (rep_left == 8'd1);
    assign pop         = m_valid && m_ready;

    assign enb     = issue;
    assign m_valid = (count != 2'd0);
    assign m_data  = fifo_data[rd_ptr];
    assign m_last  = m_valid && fifo_last[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            base_q        <= '0;
            len_q         <= '0;
            rd_left       <= '0;
            rep_left      <= 8'd0;
            addrb         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wr_ptr        <= 2'd0;
            rd_ptr        <= 2'd0;
            count         <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            done          <= 1'b0;
            inflight      <= issue;
            inflight_last <= final_issue;

            if (inflight) begin
                fifo_data[wr_ptr] <= doutb;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
            end
            case ({inflight, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            base_q   <= base;
                            len_q    <= len;
                            addrb    <= base;
                            rd_left  <= len;
                            rep_left <= rep_val;
                            busy     <= 1'b1;
                            state    <= READ;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        if (rd_left == ONE_WORD) begin
                            if (rep_left == 8'd1) begin
                                state <= DRAIN;
                            end else begin
                                addrb    <= base_q;
                                rd_left  <= len_q;
                                rep_left <= rep_left - 8'd1;
                            end
                        end else begin
                            addrb   <= (addrb == LAST_ADDR) ? '0 : addrb + 1'b1;
                            rd_left <= rd_left - ONE_WORD;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weights_bram_reader.sv
// tb/tb_weights_bram_reader.sv - directed bench for weights_bram_reader against a preloaded BRAM model
module tb_weights_bram_reader;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [2:0] base;
    logic [3:0] len;
`ifdef WEIGHTS_RD_REPEAT_EN
    logic [7:0] reps;
`endif
    logic       busy, done, enb, m_valid, m_ready, m_last;
    logic [2:0] addrb;
    logic [7:0] doutb, m_data;
    logic [7:0] mem [8];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc;
    int n_iss, n_beat, n_valid, n_done, first_enb, first_valid, done_cyc, max_ahead, stable_bad;
    int q_addr[$], q_data[$], q_last[$];
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (enb) doutb <= mem[addrb];

    weights_bram_reader #(.R_DEPTH(8), .R_DATA_WIDTH(8)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .base    (base),
        .len     (len),
`ifdef WEIGHTS_RD_REPEAT_EN
        .reps    (reps),
`endif
        .busy    (busy),
        .done    (done),
        .enb     (enb),
        .addrb   (addrb),
        .doutb   (doutb),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last)
    );

    always @(negedge clk) begin
        if (rstn) begin
            if (enb) begin
                n_iss++;
                q_addr.push_back(int'(addrb));
                if (first_enb < 0) first_enb = cyc;
            end
            if (n_iss - n_beat > max_ahead) max_ahead = n_iss - n_beat;
            if (m_valid) begin
                n_valid++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stable_bad++;
            if (m_valid && m_ready) begin
                n_beat++;
                q_data.push_back(int'(m_data));
                q_last.push_back(int'(m_last));
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        n_iss = 0; n_beat = 0; n_valid = 0; n_done = 0;
        first_enb = -1; first_valid = -1; done_cyc = -1;
        max_ahead = 0; stable_bad = 0;
        q_addr.delete(); q_data.delete(); q_last.delete();
    endtask

    // Called at posedge+1; start is held for exactly one cycle.
    task automatic run_block(input int b, input int l, input int r, input bit toggle);
        clear_stats();
        base = 3'(b); len = 4'(l); start = 1'b1; m_ready = 1'b1; start_cyc = cyc;
`ifdef WEIGHTS_RD_REPEAT_EN
        reps = 8'(r);
`endif
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 300 && n_done == 0; i++) begin
            if (toggle) m_ready = ~m_ready;
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_block(input string tag, input int b, input int l, input int r);
        int n;
        n = l * r;
        chk({tag, " beats"}, q_data.size(), n);
        chk({tag, " reads"}, q_addr.size(), n);
        for (int k = 0; k < n && k < q_data.size() && k < q_addr.size(); k++) begin
            int a;
            a = (b + k % l) % 8;
            chk($sformatf("%s addr%0d", tag, k), q_addr[k], a);
            chk($sformatf("%s data%0d", tag, k), q_data[k], a + 16);
            chk($sformatf("%s last%0d", tag, k), q_last[k], (k == n - 1) ? 1 : 0);
        end
        chk({tag, " done count"}, n_done, 1);
        chk({tag, " max ahead"}, (max_ahead <= 3) ? 1 : 0, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " enb"}, int'(enb), 0);
        chk({tag, " addrb"}, int'(addrb), 0);
        chk({tag, " m_valid"}, int'(m_valid), 0);
        chk({tag, " m_data"}, int'(m_data), 0);
        chk({tag, " m_last"}, int'(m_last), 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'(i + 16);
        rstn = 1'b0; start = 1'b0; base = '0; len = '0; m_ready = 1'b1;
`ifdef WEIGHTS_RD_REPEAT_EN
        reps = 8'd0;
`endif
        clear_stats();
        #2;
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        run_block(2, 4, 1, 1'b0);
        check_block("b2l4", 2, 4, 1);
        chk("b2l4 first enb", first_enb - start_cyc, 1);
        chk("b2l4 first valid", first_valid - start_cyc, 3);
        chk("b2l4 no bubbles", n_valid, 4);
        chk("b2l4 busy after", int'(busy), 0);

        run_block(6, 4, 1, 1'b0);
        check_block("wrap", 6, 4, 1);

        run_block(0, 8, 1, 1'b1);
        check_block("stall", 0, 8, 1);
        chk("stall held stable", stable_bad, 0);

        run_block(3, 0, 1, 1'b0);
        chk("len0 done cycle", done_cyc - start_cyc, 1);
        chk("len0 done count", n_done, 1);
        chk("len0 enb", n_iss, 0);
        chk("len0 m_valid", n_valid, 0);

        clear_stats();
        base = 3'd0; len = 4'd8; start = 1'b1; m_ready = 1'b1;
`ifdef WEIGHTS_RD_REPEAT_EN
        reps = 8'd1;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 50 && q_data.size() < 2; i++) begin
            @(negedge clk); #1;
        end
        chk("abort beats before reset", q_data.size(), 2);
        chk("abort busy before reset", int'(busy), 1);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check_outputs_zero("abort");
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort no done", n_done, 0);
        chk("abort no enb", int'(enb), 0);

        run_block(1, 2, 1, 1'b0);
        check_block("after abort", 1, 2, 1);
        chk("after abort first valid", first_valid - start_cyc, 3);

`ifdef WEIGHTS_RD_REPEAT_EN
        run_block(0, 3, 2, 1'b0);
        check_block("reps2", 0, 3, 2);
        run_block(5, 2, 0, 1'b0);
        check_block("reps0", 5, 2, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
